// File: rtl/player_collision.sv
// player_collision: predicts the next player position and probes a tile ROM for per-side collisions
module player_collision #(
    parameter int GRID_X0    = 144,
    parameter int GRID_Y0    = 35,
    parameter int TILE_SHIFT = 5,
    parameter int COLS       = 20,
    parameter int ROWS       = 15,
    parameter int ADDR_W     = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [31:0]       playerState,
    output logic [ADDR_W-1:0] tile_addr,
    input  logic              tile_solid,
    output logic [3:0]        playerCol,
    output logic              col_valid,
    output logic              busy
);
    localparam logic [9:0]        X_LO   = 10'(GRID_X0);
    localparam logic [9:0]        X_HI   = 10'(GRID_X0 + (COLS << TILE_SHIFT) - 1);
    localparam logic [9:0]        Y_LO   = 10'(GRID_Y0);
    localparam logic [9:0]        Y_HI   = 10'(GRID_Y0 + (ROWS << TILE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

    typedef enum logic [2:0] {IDLE, REQ_H, WAIT_H, REQ_V, WAIT_V, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tile_addr_q, tile_addr_d, v_addr_q, v_addr_d;
    logic              h_out_q, h_out_d, v_out_q, v_out_d;
    logic              x_dir_q, x_dir_d, y_dir_q, y_dir_d;
    logic              hsolid_q, hsolid_d;
    logic [3:0]        player_col_q, player_col_d;
    logic              col_valid_q, col_valid_d;
    logic [9:0]        x, y, nx, ny;
    logic [9:0]        xs, ys;
    logic [ADDR_W:0]   h_probe, v_probe;
    logic              v_solid;

    // Returns {out_of_field, address}; out-of-field points map to address 0
    function automatic logic [ADDR_W:0] probe(input logic [9:0] px, input logic [9:0] py);
        logic [9:0] dx, dy;
        logic       in_f;
        dx   = px - X_LO;
        dy   = py - Y_LO;
        in_f = px >= X_LO && px <= X_HI && py >= Y_LO && py <= Y_HI;
        return in_f ? {1'b0, ADDR_W'(dy >> TILE_SHIFT) * COLS_A + ADDR_W'(dx >> TILE_SHIFT)}
                    : {1'b1, {ADDR_W{1'b0}}};
    endfunction

    // Position prediction and probe mapping from the live playerState
    always_comb begin
        x       = playerState[31:22];
        y       = playerState[21:12];
        xs      = {5'd0, playerState[11:7]};
        ys      = {5'd0, playerState[6:2]};
        nx      = playerState[1] ? x + xs : x - xs;
        ny      = playerState[0] ? y - ys : (ys == 10'd0 ? y + 10'd1 : y + ys);
        h_probe = probe(nx, y);
        v_probe = probe(x, ny);
    end

    // FSM next-state and registered-output computation, one state per cycle
    always_comb begin
        state_d      = state_q;
        tile_addr_d  = tile_addr_q;
        v_addr_d     = v_addr_q;
        h_out_d      = h_out_q;
        v_out_d      = v_out_q;
        x_dir_d      = x_dir_q;
        y_dir_d      = y_dir_q;
        hsolid_d     = hsolid_q;
        player_col_d = player_col_q;
        col_valid_d  = 1'b0;
        v_solid      = tile_solid | v_out_q;
        case (state_q)
            IDLE: if (tick) begin
                state_d     = REQ_H;
                tile_addr_d = h_probe[ADDR_W-1:0];
                h_out_d     = h_probe[ADDR_W];
                v_addr_d    = v_probe[ADDR_W-1:0];
                v_out_d     = v_probe[ADDR_W];
                x_dir_d     = playerState[1];
                y_dir_d     = playerState[0];
            end
            REQ_H:  state_d = WAIT_H;
            WAIT_H: begin
                hsolid_d    = tile_solid | h_out_q;
                tile_addr_d = v_addr_q;
                state_d     = REQ_V;
            end
            REQ_V:  state_d = WAIT_V;
            WAIT_V: begin
                player_col_d = {v_solid & y_dir_q, hsolid_q & x_dir_q, v_solid & ~y_dir_q, hsolid_q & ~x_dir_q};
                col_valid_d  = 1'b1;
                state_d      = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any probe in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tile_addr_q  <= '0;
            v_addr_q     <= '0;
            h_out_q      <= 1'b0;
            v_out_q      <= 1'b0;
            x_dir_q      <= 1'b0;
            y_dir_q      <= 1'b0;
            hsolid_q     <= 1'b0;
            player_col_q <= 4'd0;
            col_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tile_addr_q  <= tile_addr_d;
            v_addr_q     <= v_addr_d;
            h_out_q      <= h_out_d;
            v_out_q      <= v_out_d;
            x_dir_q      <= x_dir_d;
            y_dir_q      <= y_dir_d;
            hsolid_q     <= hsolid_d;
            player_col_q <= player_col_d;
            col_valid_q  <= col_valid_d;
        end
    end

    assign tile_addr = tile_addr_q;
    assign playerCol = player_col_q;
    assign col_valid = col_valid_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_player_collision.sv
// tb_player_collision: randomized and directed checks of player_collision against an arithmetic model
module tb_player_collision;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [31:0] playerState = '0;
    logic [8:0]  tile_addr;
    logic        tile_solid = 1'b0;
    logic [3:0]  playerCol;
    logic        col_valid;
    logic        busy;
    logic        rom [0:511];
    int          tests = 0;
    int          fails = 0;

    player_collision dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .playerState(playerState),
        .tile_addr(tile_addr), .tile_solid(tile_solid), .playerCol(playerCol),
        .col_valid(col_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous tile ROM: data appears the cycle after the address
    always @(posedge clk) tile_solid <= rom[tile_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void map_pt(input int px, input int py, output int a, output bit s);
        bit in_f;
        in_f = px >= 144 && px < 144 + 640 && py >= 35 && py < 35 + 480;
        a = in_f ? ((py - 35) / 32) * 20 + (px - 144) / 32 : 0;
        s = in_f ? rom[a] : 1'b1;
    endfunction

    function automatic void model(input logic [31:0] ps, output int ha, output int va, output logic [3:0] col);
        int x, y, xs, ys, nx, ny;
        bit xd, yd, hs, vs;
        x  = int'(ps[31:22]);
        y  = int'(ps[21:12]);
        xs = int'(ps[11:7]);
        ys = int'(ps[6:2]);
        xd = ps[1];
        yd = ps[0];
        nx = xd ? (x + xs) % 1024 : (x - xs + 1024) % 1024;
        ny = yd ? (y - ys + 1024) % 1024 : (ys == 0 ? (y + 1) % 1024 : (y + ys) % 1024);
        map_pt(nx, y, ha, hs);
        map_pt(x, ny, va, vs);
        col = {vs && yd, hs && xd, vs && !yd, hs && !xd};
    endfunction

    function automatic logic [31:0] mk(input int x, input int y, input int xs, input int ys, input bit xd, input bit yd);
        return {10'(x), 10'(y), 5'(xs), 5'(ys), xd, yd};
    endfunction

    // One full probe transaction; optional extra tick while busy must be ignored
    task automatic run(input string tag, input logic [31:0] ps, input bit noise);
        int ha, va;
        logic [3:0] col;
        model(ps, ha, va, col);
        @(negedge clk);
        playerState = ps;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check({tag, " h_addr"}, 32'(tile_addr), 32'(ha));
        check({tag, " busy"}, 32'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        check({tag, " v_addr"}, 32'(tile_addr), 32'(va));
        if (noise) begin
            tick = 1'b1;
            playerState = $urandom;
        end
        @(negedge clk);
        tick = 1'b0;
        check({tag, " early_valid"}, 32'(col_valid), 0);
        @(negedge clk);
        check({tag, " col_valid"}, 32'(col_valid), 1);
        check({tag, " col"}, 32'(playerCol), 32'(col));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        for (int i = 0; i < 512; i++) rom[i] = 1'($urandom);
        rom[41] = 1'b0;
        rom[61] = 1'b1;
        rom[1]  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst col", 32'(playerCol), 0);
        check("rst valid", 32'(col_valid), 0);
        check("rst busy", 32'(busy), 0);
        check("rst addr", 32'(tile_addr), 0);
        rst_n = 1'b1;

        run("ground", mk(176, 99, 4, 0, 1, 0), 0);
        check("ground exact", 32'(playerCol), 32'b0000);
        run("floor", mk(176, 130, 4, 0, 1, 0), 0);
        check("floor exact", 32'(playerCol), 32'b0010);
        run("rwall", mk(780, 99, 4, 0, 1, 0), 0);
        check("rwall bit2", 32'(playerCol[2]), 1);

        // Reset while waiting on the horizontal ROM read
        @(negedge clk);
        playerState = mk(176, 99, 4, 0, 1, 0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst col", 32'(playerCol), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst valid", 32'(col_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (col_valid) seen++;
        end
        check("midrst no_pulse", 32'(seen), 0);

        run("lwrap", mk(2, 99, 4, 0, 0, 0), 0);
        check("lwrap bit0", 32'(playerCol[0]), 1);
        run("ceil", mk(176, 70, 0, 17, 0, 1), 0);
        check("ceil bit3", 32'(playerCol[3]), 1);
        run("b2b", mk(200, 300, 7, 9, 1, 1), 1);
        run("chain", mk(500, 200, 3, 2, 0, 1), 0);

        for (int i = 0; i < 40; i++)
            run("rand", mk($urandom_range(120, 800), $urandom_range(20, 530), $urandom_range(0, 31),
                           $urandom_range(0, 31), 1'($urandom), 1'($urandom)), 1'($urandom));

        @(negedge clk);
        check("end valid", 32'(col_valid), 0);
        check("end busy", 32'(busy), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
